// File: rtl/datapath_seq_pkg.sv
// Shared types for the datapath sequencer:
// FSM states, instruction classes and field positions.
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_CONST,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOADI = 2'b01,
        CLS_COPY  = 2'b10,
        CLS_HALT  = 2'b11
    } insn_class_e;

    localparam int OP_LSB   = 29;
    localparam int FORM_BIT = 28;
    localparam int VEC_LSB  = 26;
    localparam int A_LSB    = 22;
    localparam int B_LSB    = 18;
    localparam int C_LSB    = 14;
    localparam int D_LSB    = 10;
    localparam int Y1_LSB   = 6;
    localparam int Y2_LSB   = 2;
    localparam int CLS_LSB  = 0;

    typedef struct packed {
        logic [2:0] op;
        logic       form;
        logic [1:0] vec;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] y1;
        logic [3:0] y2;
    } insn_fields_t;

    function automatic insn_class_e word_class(
        input logic [31:0] w
    );
        return insn_class_e'(w[CLS_LSB +: 2]);
    endfunction

endpackage

// File: rtl/datapath_sequencer_decode.sv
// Combinational instruction decoder: splits a word
// into fields, class and the zero-operand flags.
module insn_decode
    import datapath_seq_pkg::*;
(
    input  logic [31:0]  word_i,
    output insn_fields_t fields_o,
    output insn_class_e  cls_o,
    output logic [3:0]   zero_reg_o
);

    assign fields_o.op   = word_i[OP_LSB +: 3];
    assign fields_o.form = word_i[FORM_BIT];
    assign fields_o.vec  = word_i[VEC_LSB +: 2];
    assign fields_o.a    = word_i[A_LSB +: 4];
    assign fields_o.b    = word_i[B_LSB +: 4];
    assign fields_o.c    = word_i[C_LSB +: 4];
    assign fields_o.d    = word_i[D_LSB +: 4];
    assign fields_o.y1   = word_i[Y1_LSB +: 4];
    assign fields_o.y2   = word_i[Y2_LSB +: 4];
    assign cls_o         = word_class(word_i);

    assign zero_reg_o = {
        fields_o.d == 4'd0,
        fields_o.c == 4'd0,
        fields_o.b == 4'd0,
        fields_o.a == 4'd0
    };

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer: fetches words from imem,
// holds the decoded instruction and pulses datapath controls.
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [2:0]  op,
    output logic        form,
    output logic [1:0]  vec,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic [3:0]  Y1,
    output logic [3:0]  Y2,
    output logic [3:0]  zero_reg,
    output logic [1:0]  write,
    output logic        const_a,
    output logic [31:0] constant,
    output logic        program_counter_inc,
    output logic        copy_neg,
    output logic [3:0]  copy_select,
    output logic        busy,
    output logic        halted,
    output logic [15:0] pc
);

    state_e       state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [31:0]  insn_q, insn_d;
    logic [31:0]  const_q, const_d;
    insn_fields_t fld;
    insn_class_e  cls;

    insn_decode u_dec (
        .word_i     (insn_q),
        .fields_o   (fld),
        .cls_o      (cls),
        .zero_reg_o (zero_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            insn_q  <= '0;
            const_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            const_q <= const_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        insn_d              = insn_q;
        const_d             = const_q;
        imem_req            = 1'b0;
        write               = 2'b00;
        const_a             = 1'b0;
        program_counter_inc = 1'b0;
        copy_neg            = 1'b0;
        copy_select         = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    insn_d = imem_rdata;
                    pc_d   = pc_q + 16'd1;
                    unique case (word_class(imem_rdata))
                        CLS_LOADI: state_d = S_FETCH_CONST;
                        CLS_HALT:  state_d = S_HALT;
                        default:   state_d = S_EXEC;
                    endcase
                end
            end
            S_FETCH_CONST: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    const_d = imem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                program_counter_inc = 1'b1;
                unique case (cls)
                    CLS_ALU:
                        write = fld.form ? 2'b10 : 2'b01;
                    CLS_LOADI: begin
                        write   = 2'b01;
                        const_a = 1'b1;
                    end
                    CLS_COPY: begin
                        write       = 2'b01;
                        copy_neg    = fld.form;
                        copy_select = fld.d;
                    end
                    CLS_HALT: write = 2'b00;
                endcase
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign op        = fld.op;
    assign form      = fld.form;
    assign vec       = fld.vec;
    assign A         = fld.a;
    assign B         = fld.b;
    assign C         = fld.c;
    assign D         = fld.d;
    assign Y1        = fld.y1;
    assign Y2        = fld.y2;
    assign constant  = const_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign busy      = (state_q != S_IDLE) &&
                       (state_q != S_HALT);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small
// imem responder whose ack latency is programmable.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  A, B, C, D, Y1, Y2;
    logic [3:0]  zero_reg;
    logic [1:0]  write;
    logic        const_a;
    logic [31:0] constant;
    logic        pc_inc;
    logic        copy_neg;
    logic [3:0]  copy_select;
    logic        busy, halted;
    logic [15:0] pc;

    // second instance starts at the top of the address space
    logic        x_run = 1'b0;
    logic        x_req;
    logic [15:0] x_addr;
    logic        x_ack = 1'b0;
    logic [31:0] x_rdata = 32'h0000_0040;
    logic [2:0]  x_op;
    logic        x_form;
    logic [1:0]  x_vec;
    logic [3:0]  x_a, x_b, x_c, x_d, x_y1, x_y2;
    logic [3:0]  x_zero;
    logic [1:0]  x_write;
    logic        x_ca;
    logic [31:0] x_const;
    logic        x_inc;
    logic        x_cneg;
    logic [3:0]  x_csel;
    logic        x_busy, x_halted;
    logic [15:0] x_pc;

    logic [31:0] mem [0:15];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_inc = 0;
    int          n_wr = 0;
    int          n_wr2 = 0;

    datapath_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .op(op), .form(form), .vec(vec),
        .A(A), .B(B), .C(C), .D(D),
        .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg),
        .write(write), .const_a(const_a),
        .constant(constant),
        .program_counter_inc(pc_inc),
        .copy_neg(copy_neg),
        .copy_select(copy_select),
        .busy(busy), .halted(halted), .pc(pc)
    );

    datapath_sequencer #(.RESET_PC(16'hFFFF)) dut_top (
        .clk(clk), .rst(rst), .run(x_run),
        .imem_req(x_req), .imem_addr(x_addr),
        .imem_ack(x_ack), .imem_rdata(x_rdata),
        .op(x_op), .form(x_form), .vec(x_vec),
        .A(x_a), .B(x_b), .C(x_c), .D(x_d),
        .Y1(x_y1), .Y2(x_y2), .zero_reg(x_zero),
        .write(x_write), .const_a(x_ca),
        .constant(x_const),
        .program_counter_inc(x_inc),
        .copy_neg(x_cneg),
        .copy_select(x_csel),
        .busy(x_busy), .halted(x_halted), .pc(x_pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[3:0]];
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
        x_ack = x_req;
    end

    always @(negedge clk) begin
        if (pc_inc) n_inc++;
        if (write != 2'b00) n_wr++;
        if (write == 2'b10) n_wr2++;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h0000_0041; // LOADI Y1=1
        mem[1] = 32'h0000_0005; // constant
        mem[2] = 32'h9048_0C0C; // ALU op4 f1 A1 B2 D3 Y2=3
        mem[3] = 32'h1000_1402; // COPY neg D=5
        mem[4] = 32'h0000_0003; // HALT
        mem[5] = 32'h0000_0080; // ALU f0 Y1=2
        mem[6] = 32'h0000_0040; // ALU f0 Y1=1

        #3 rst = 1'b1;
        step();
        check("rst_pc", pc, 16'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_write", write, 2'b00);
        check("rst_inc", pc_inc, 1'b0);
        check("rst_ca", const_a, 1'b0);
        check("rst_const", constant, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_halt", halted, 1'b0);
        check("rst_op", op, 3'd0);
        check("rst_zero", zero_reg, 4'hF);

        rst = 1'b0;
        run = 1'b1;
        step(); // FETCH word 0
        check("f0_req", imem_req, 1'b1);
        check("f0_addr", imem_addr, 16'd0);
        check("f0_busy", busy, 1'b1);
        check("f0_write", write, 2'b00);
        step(); // FETCH_CONST
        check("fc_pc", pc, 16'd1);
        check("fc_req", imem_req, 1'b1);
        step(); // EXEC LOADI
        check("li_write", write, 2'b01);
        check("li_ca", const_a, 1'b1);
        check("li_const", constant, 32'd5);
        check("li_pc", pc, 16'd2);
        check("li_inc", pc_inc, 1'b1);
        check("li_y1", Y1, 4'd1);
        check("li_req", imem_req, 1'b0);
        step(); // FETCH ALU
        check("f2_req", imem_req, 1'b1);
        check("f2_addr", imem_addr, 16'd2);
        check("f2_write", write, 2'b00);
        check("f2_ca", const_a, 1'b0);
        step(); // EXEC ALU
        check("alu_write", write, 2'b10);
        check("alu_ca", const_a, 1'b0);
        check("alu_op", op, 3'b100);
        check("alu_form", form, 1'b1);
        check("alu_y2", Y2, 4'd3);
        check("alu_a", A, 4'd1);
        check("alu_b", B, 4'd2);
        check("alu_d", D, 4'd3);
        check("alu_vec", vec, 2'd0);
        check("alu_zero", zero_reg, 4'b0100);
        check("alu_inc", pc_inc, 1'b1);
        check("alu_pc", pc, 16'd3);
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            step(); // FETCH held until ack
            check("dly_req", imem_req, 1'b1);
            check("dly_addr", imem_addr, 16'd3);
            check("dly_write", write, 2'b00);
        end
        step(); // EXEC COPY
        check("cp_write", write, 2'b01);
        check("cp_neg", copy_neg, 1'b1);
        check("cp_sel", copy_select, 4'd5);
        check("cp_pc", pc, 16'd4);
        check("cp_ca", const_a, 1'b0);
        ack_delay = 0;
        step(); // FETCH HALT word
        check("fh_addr", imem_addr, 16'd4);
        step(); // HALT
        check("h_halted", halted, 1'b1);
        check("h_busy", busy, 1'b0);
        check("h_inc", pc_inc, 1'b0);
        check("h_req", imem_req, 1'b0);
        check("h_pc", pc, 16'd5);
        run = 1'b0;
        step(); // IDLE
        check("i_halted", halted, 1'b0);
        check("i_busy", busy, 1'b0);
        run = 1'b1;
        step(); // resume at pc 5
        check("rs_req", imem_req, 1'b1);
        check("rs_addr", imem_addr, 16'd5);
        step(); // EXEC ALU form 0
        check("a0_write", write, 2'b01);
        check("a0_y1", Y1, 4'd2);
        check("a0_pc", pc, 16'd6);
        run = 1'b0;
        step(); // IDLE
        check("stop_busy", busy, 1'b0);
        check("stop_req", imem_req, 1'b0);

        ack_delay = 2;
        run = 1'b1;
        step(); // FETCH word 6
        check("mf_addr", imem_addr, 16'd6);
        run = 1'b0;
        step();
        check("mf_req1", imem_req, 1'b1);
        check("mf_wr", write, 2'b00);
        step();
        check("mf_req2", imem_req, 1'b1);
        step(); // EXEC despite run=0
        check("mf_inc", pc_inc, 1'b1);
        check("mf_write", write, 2'b01);
        check("mf_pc", pc, 16'd7);
        step();
        check("mf_idle", busy, 1'b0);
        check("mf_ireq", imem_req, 1'b0);

        ack_delay = 5;
        run = 1'b1;
        step(); // FETCH pending
        check("rf_req", imem_req, 1'b1);
        #2 rst = 1'b1;
        run = 1'b0;
        #1;
        check("rf_req0", imem_req, 1'b0);
        check("rf_pc", pc, 16'd0);
        check("rf_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("rf_idle", busy, 1'b0);
        check("rf_pc2", pc, 16'd0);
        check("rf_req2", imem_req, 1'b0);
        check("wr_top", x_pc, 16'hFFFF);

        x_run = 1'b1;
        step();
        check("wr_req", x_req, 1'b1);
        check("wr_addr", x_addr, 16'hFFFF);
        step();
        check("wr_pc", x_pc, 16'h0000);
        check("wr_inc", x_inc, 1'b1);
        check("wr_write", x_write, 2'b01);
        x_run = 1'b0;
        step();
        #1;
        check("n_inc", n_inc, 5);
        check("n_wr", n_wr, 5);
        check("n_wr2", n_wr2, 1);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: run  input  1  level; 1 = execute program, 0 = stop after current instruction.
REQ-004 SHALL have port: imem_req  output  1  instruction-word read request.
REQ-005 SHALL have port: imem_addr  output  16  word address; equals pc.
REQ-006 SHALL have port: imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  instruction or constant word.
REQ-008 SHALL have datapath control outputs: op 3, form 1, vec 2, A 4, B 4, C 4, D 4, Y1 4, Y2 4, zero_reg 4, write 2, const_a 1, constant 32, program_counter_inc 1, copy_neg 1, copy_select 4.
REQ-009 SHALL have status outputs: busy 1 (state not IDLE/HALT), halted 1 (state HALT), pc 16.

Function
REQ-010 SHALL decode instruction fields: op[31:29], form[28], vec[27:26], A[25:22], B[21:18], C[17:14], D[13:10], Y1[9:6], Y2[5:2], class[1:0].
REQ-011 SHALL support classes: 00 ALU, 01 LOADI (the next word is the constant), 10 COPY, 11 HALT.
REQ-012 SHALL implement states IDLE, FETCH, FETCH_CONST, EXEC and HALT.
REQ-013 SHALL take these transitions:
- IDLE->FETCH when run=1.
- FETCH->EXEC on ack with class ALU or COPY.
- FETCH->FETCH_CONST on ack with LOADI.
- FETCH->HALT on ack with HALT.
- FETCH_CONST->EXEC on ack.
- EXEC->FETCH if run=1, else IDLE.
- HALT->IDLE when run=0.
REQ-014 SHALL hold imem_req=1 in FETCH/FETCH_CONST until imem_ack, keeping imem_addr stable, and 0 in all other states.
REQ-015 SHALL ignore imem_ack while imem_req=0.
REQ-016 SHALL capture imem_rdata on the ack cycle, with decoded fields registered and stable from EXEC entry until the next instruction is captured.
REQ-017 SHALL increment pc by 1 on every accepted ack, including constant words, wrapping 16'hFFFF->0.
REQ-018 SHALL drive write, for one cycle in EXEC only (2'b00 elsewhere):
- ALU: form=0 -> 2'b01 (Y1), form=1 -> 2'b10 (Y2).
- LOADI: 2'b01.
- COPY: 2'b01.
REQ-019 SHALL drive const_a=1 and constant=captured constant word during LOADI EXEC, else const_a=0.
REQ-020 SHALL drive copy_select=D field and copy_neg=form during COPY EXEC, else copy_select=0 and copy_neg=0.
REQ-021 SHALL drive zero_reg[k]=1 iff operand field k (A,B,C,D for k=0..3) equals 4'd0.
REQ-022 SHALL pulse program_counter_inc for exactly one cycle per executed instruction, in its EXEC cycle; HALT is not executed.
REQ-023 SHALL, when run falls mid-fetch, complete the fetch and EXEC of the current instruction, then enter IDLE.
REQ-024 SHALL give 2 cycles per ALU instruction and 3 per LOADI when ack is returned in the same cycle as req.

Reset
REQ-025 SHALL, on rst assertion and independent of clk, enter IDLE with pc=0, imem_req=0, write=0, program_counter_inc=0, const_a=0, constant=0, all fields 0, busy=0 and halted=0.
REQ-026 SHALL, on reset during FETCH, drop imem_req immediately and discard the pending ack.

Structure
REQ-027 SHALL place the state enum, class codes and field bit positions in shared package datapath_seq_pkg.
REQ-028 SHALL use a combinational sub-module insn_decode (word -> fields, class, zero_reg).

Verification
REQ-029 SHALL cover: LOADI Y1=1 followed by constant 5, with immediate ack -> write=01, const_a=1, constant=5 in EXEC, and pc=2.
REQ-030 SHALL cover: ALU op=100, form=1, Y2=3 -> single write=10 cycle, one program_counter_inc pulse, const_a=0.
REQ-031 SHALL cover: ack delayed 3 cycles -> imem_req and imem_addr held constant and no write until ack.
REQ-032 SHALL cover: HALT word -> halted=1, no program_counter_inc; run=0 -> IDLE; run=1 -> fetch resumes at next pc.
REQ-033 SHALL cover: pc=16'hFFFF ALU fetch -> pc=0; rst mid-FETCH -> imem_req=0 same cycle, pc=0.
